// File: rtl/mae_macc_sequencer.sv
// Job sequencer for one MAE DSP tile used as a multiply-accumulator in feedback mode.
// Streams LEN operand pairs into the tile, steers P enable/feedback, and returns the final P.
`timescale 1ns/1ps

module mae_macc_sequencer #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int P_WIDTH   = 40,
    parameter int LEN_WIDTH = 16,
    parameter int MULT_LAT  = 0
) (
    input  logic                 CLK,
    input  logic                 ARST_N,
    input  logic                 START,
    input  logic [LEN_WIDTH-1:0] LEN,
    input  logic                 ABORT,
    output logic                 BUSY,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [A_WIDTH-1:0]   IN_A,
    input  logic [B_WIDTH-1:0]   IN_B,
    output logic [A_WIDTH-1:0]   DSP_A,
    output logic [B_WIDTH-1:0]   DSP_B,
    output logic                 DSP_FDBK_SEL,
    output logic                 DSP_P_EN,
    output logic                 DSP_P_SRST_N,
    input  logic [P_WIDTH-1:0]   DSP_P,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [P_WIDTH-1:0]   RES_DATA,
    output logic [1:0]           DBG_STATE
);

    // Handshakes: a transfer happens on a CLK edge where valid and ready are both high;
    // valid never depends on ready, and ABORT overrides every handshake in that cycle.

    localparam int PIPE = MULT_LAT + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [P_WIDTH-1:0]   res_q, res_d;
    logic [A_WIDTH-1:0]   dsp_a_q;
    logic [B_WIDTH-1:0]   dsp_b_q;
    logic [PIPE-1:0]      tok_q, tok_d;
    logic [PIPE-1:0]      first_q, first_d;
    logic                 fdbk_q;
    logic                 srst_n_q;
    logic                 accept;
    logic                 last_pair;

    assign IN_READY  = (state_q == ST_RUN) && (count_q != len_q);
    assign accept    = IN_VALID && IN_READY && !ABORT;
    // count_q < len_q whenever this is used, so the increment cannot wrap
    assign last_pair = ((count_q + LEN_WIDTH'(1)) == len_q);

    // Token bit 0 is the pair now entering DSP_A/B; bit MULT_LAT is the one enabling P.
    always_comb begin
        tok_d   = '0;
        first_d = '0;
        if (!ABORT) begin
            tok_d   = (tok_q << 1) | PIPE'(accept);
            first_d = (first_q << 1) | PIPE'(accept && (count_q == '0));
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        res_d   = res_q;
        if (ABORT) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        count_d = '0;
                        if (LEN != '0) begin
                            len_d   = LEN;
                            state_d = ST_RUN;
                        end else begin
                            res_d   = '0;
                            state_d = ST_RESULT;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        count_d = count_q + LEN_WIDTH'(1);
                        if (last_pair) state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Pipe empty means the last P update has already landed on DSP_P.
                    if (tok_q == '0) begin
                        res_d   = DSP_P;
                        state_d = ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (RES_READY) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            count_q  <= '0;
            res_q    <= '0;
            dsp_a_q  <= '0;
            dsp_b_q  <= '0;
            tok_q    <= '0;
            first_q  <= '0;
            fdbk_q   <= 1'b0;
            srst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            count_q  <= count_d;
            res_q    <= res_d;
            tok_q    <= tok_d;
            first_q  <= first_d;
            // Loading the first product instead of adding drops any P left by the previous job.
            fdbk_q   <= !(tok_d[MULT_LAT] && first_d[MULT_LAT]);
            srst_n_q <= !ABORT;
            if (accept) begin
                dsp_a_q <= IN_A;
                dsp_b_q <= IN_B;
            end
        end
    end

    assign BUSY         = (state_q != ST_IDLE);
    assign DSP_A        = dsp_a_q;
    assign DSP_B        = dsp_b_q;
    assign DSP_FDBK_SEL = fdbk_q;
    assign DSP_P_EN     = tok_q[MULT_LAT];
    assign DSP_P_SRST_N = srst_n_q;
    assign RES_VALID    = (state_q == ST_RESULT);
    assign RES_DATA     = res_q;
    assign DBG_STATE    = state_q;

endmodule
